freelist_ctrl: RTL and testbench
================================

Name: freelist_ctrl

Overview:
Allocation/release controller in front of the physical-register freelist FIFO (2 read ports, 2 write ports, registered occupancy count). Grants up to two rename-lane tag allocations per cycle, stages commit-time tag releases in a small buffer, and sequences branch-rollback tag returns through an FSM. Only this block drives the freelist's read and write enables.

Parameters:
PREG_NUM, 31, freelist capacity in tags
TAG_W, 5, physical tag width
CNT_W, 5, freelist occupancy width
REL_BUF_DEPTH, 4, release staging buffer entries (power of 2, ≥2)

Ports:
clk  in  1  clock
rst  in  1  reset
alloc_req_first_i  in  1  rename lane 0 requests a tag
alloc_req_second_i  in  1  rename lane 1 requests a tag
alloc_gnt_first_o  out  1  lane 0 granted
alloc_gnt_second_o  out  1  lane 1 granted
alloc_tag_first_o  out  TAG_W  lane 0 tag
alloc_tag_second_o  out  TAG_W  lane 1 tag
rel_first_en_i  in  1  commit release, slot 0
rel_second_en_i  in  1  commit release, slot 1
rel_tag_first_i  in  TAG_W  released tag, slot 0
rel_tag_second_i  in  TAG_W  released tag, slot 1
rel_ready_o  out  1  release buffer has ≥2 free slots
rb_start_i  in  1  rollback begins
rb_valid_first_i  in  1  rollback tag valid, slot 0
rb_valid_second_i  in  1  rollback tag valid, slot 1
rb_tag_first_i  in  TAG_W  rollback tag, slot 0
rb_tag_second_i  in  TAG_W  rollback tag, slot 1
rb_done_i  in  1  last rollback beat
fl_rd_first_en_o  out  1  freelist read enable, port 0
fl_rd_second_en_o  out  1  freelist read enable, port 1
fl_rdata_first_i  in  TAG_W  freelist head tag
fl_rdata_second_i  in  TAG_W  freelist head+1 tag
fl_wr_first_en_o  out  1  freelist write enable, port 0
fl_wr_second_en_o  out  1  freelist write enable, port 1
fl_wdata_first_o  out  TAG_W  freelist write data, port 0
fl_wdata_second_o  out  TAG_W  freelist write data, port 1
fl_num_i  in  CNT_W  freelist occupancy (registered)
busy_o  out  1  state != RUN

Behaviour:
- Reset is synchronous and active-high on rst, with one clock clk. During reset: state=RUN, release buffer empty, all enables and grants 0, rel_ready_o=1, busy_o=0. Reset mid-rollback discards the rollback and all buffered releases.
- FSM states: RUN, ROLLBACK, DRAIN.
  - RUN→ROLLBACK on rb_start_i.
  - ROLLBACK→DRAIN on rb_done_i if the buffer is non-empty after that cycle's pops; otherwise ROLLBACK→RUN.
  - DRAIN→RUN when the buffer becomes empty.
  - rb_start_i is ignored outside RUN. rb_done_i and rb_valid_* are sampled only in ROLLBACK.
- Allocation is combinational, zero latency, and occurs only in RUN with rb_start_i=0:
  - gnt_first = req_first & (fl_num_i ≥ 1).
  - gnt_second = req_second & gnt_first & (fl_num_i ≥ 2). Grants are in order; a lane-1-only request is never granted.
  - fl_rd_first_en_o = gnt_first; fl_rd_second_en_o = gnt_second.
  - alloc_tag_* = fl_rdata_* when granted, else 0.
  - fl_num_i is not bypassed with same-cycle writes (conservative).
- Releases: accepted whenever rel_ready_o=1 and pushed into the buffer (slot 0 before slot 1). They appear on the freelist write ports no earlier than the next cycle. Pushes while rel_ready_o=0 are a protocol violation and are dropped.
- Write-port arbitration per cycle:
  - ROLLBACK: rollback tags own both ports, with wr_first=rb_valid_first_i and wr_second=rb_valid_second_i. A second-only beat is remapped to port 0, so a single write always uses port 0. Buffer pops are blocked.
  - RUN/DRAIN: pop up to 2 oldest buffer entries onto ports 0 then 1.
- Buffer push and pop in the same cycle are legal. Free-slot count = REL_BUF_DEPTH − count after the cycle's pop, registered into rel_ready_o.
- Writes never exceed PREG_NUM − fl_num_i; an excess is an upstream error and is not checked in the base build.

Optional Feature:
FREELIST_CTRL_ERR_EN
- With the macro: adds output err_o (1 bit, sticky until rst). It sets on any of: a release push while rel_ready_o=0; the cycle's writes exceeding PREG_NUM − fl_num_i; lane 1 requesting without lane 0; rb_valid_* outside ROLLBACK.
- Without the macro: no err_o port and no checking logic.

Decomposition:
- Package freelist_pkg holds the TAG_W/CNT_W defaults, the state enum (RUN, ROLLBACK, DRAIN), and the release-entry typedef.
- One sub-module, freelist_rel_buf: a 2-push/2-pop circular FIFO with count output, instantiated once.

Test Plan:
- fl_num_i=2, both lanes request, fl_rdata=7/9 → both grants, tags 7/9, both rd_en=1; then fl_num_i=1 → only gnt_first.
- fl_num_i=0, both request → no grants, rd_en=0; lane 1 alone with fl_num_i=5 → no grant.
- Release tags 3,4 in cycle N → fl_wr_first/second_en=1 with data 3/4 in cycle N+1; 4 releases in back-to-back cycles with pops blocked → rel_ready_o=0 after the second pair.
- rb_start_i, then 2 beats (tags 10/11, then second-only tag 12) with rb_done_i on the last beat, plus a concurrent release of tag 5 → writes 10/11, then 12 on port 0, then DRAIN writes 5, then RUN; grants suppressed throughout.
- Assert rst during ROLLBACK with the buffer holding 2 entries → next cycle state=RUN, busy_o=0, no writes, rel_ready_o=1.
- With FREELIST_CTRL_ERR_EN: push a release while rel_ready_o=0 → err_o=1 and stays 1 until rst.

Source files
------------

// File: rtl/freelist_pkg.sv
// Shared types and width defaults for the physical-register freelist controller.
package freelist_pkg;

   localparam int unsigned DEF_TAG_W = 5;
   localparam int unsigned DEF_CNT_W = 5;

   typedef enum logic [1:0] {
      StRun,
      StRollback,
      StDrain
   } fl_state_e;

   typedef struct packed {
      logic [DEF_TAG_W-1:0] tag;
   } rel_entry_t;

endpackage

// File: rtl/freelist_rel_buf.sv
// Release staging FIFO: up to two pushes and two pops per cycle, in-order.
module freelist_rel_buf
   import freelist_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAG_W = DEF_TAG_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_first_i,
   input  logic                     push_second_i,
   input  logic [TAG_W-1:0]         push_tag_first_i,
   input  logic [TAG_W-1:0]         push_tag_second_i,
   input  logic                     pop_first_i,
   input  logic                     pop_second_i,
   output logic [TAG_W-1:0]         head_first_o,
   output logic [TAG_W-1:0]         head_second_o,
   output logic [$clog2(DEPTH):0]   cnt_o,
   output logic [$clog2(DEPTH):0]   cnt_next_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned BC_W  = PTR_W + 1;

   logic [TAG_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [BC_W-1:0]  cnt_q;

   always_comb begin
      cnt_next_o = cnt_q + BC_W'(push_first_i) + BC_W'(push_second_i)
                 - BC_W'(pop_first_i) - BC_W'(pop_second_i);
   end

   assign cnt_o         = cnt_q;
   assign head_first_o  = mem_q[rd_ptr_q];
   assign head_second_o = mem_q[rd_ptr_q + PTR_W'(1)];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + PTR_W'(push_first_i) + PTR_W'(push_second_i);
         rd_ptr_q <= rd_ptr_q + PTR_W'(pop_first_i) + PTR_W'(pop_second_i);
         cnt_q    <= cnt_next_o;
      end
   end

   // A lone slot-1 push lands at wr_ptr so entries stay packed.
   always_ff @(posedge clk) begin
      if (push_first_i) begin
         mem_q[wr_ptr_q] <= push_tag_first_i;
      end
      if (push_second_i) begin
         mem_q[wr_ptr_q + PTR_W'(push_first_i)] <= push_tag_second_i;
      end
   end

endmodule

// File: rtl/freelist_ctrl.sv
// Freelist allocation/release/rollback controller; sole driver of freelist enables.
// Optional FREELIST_CTRL_ERR_EN adds a sticky protocol-error output err_o.
module freelist_ctrl
   import freelist_pkg::*;
#(
   parameter int unsigned PREG_NUM      = 31,
   parameter int unsigned TAG_W         = DEF_TAG_W,
   parameter int unsigned CNT_W         = DEF_CNT_W,
   parameter int unsigned REL_BUF_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc_req_first_i,
   input  logic             alloc_req_second_i,
   output logic             alloc_gnt_first_o,
   output logic             alloc_gnt_second_o,
   output logic [TAG_W-1:0] alloc_tag_first_o,
   output logic [TAG_W-1:0] alloc_tag_second_o,
   input  logic             rel_first_en_i,
   input  logic             rel_second_en_i,
   input  logic [TAG_W-1:0] rel_tag_first_i,
   input  logic [TAG_W-1:0] rel_tag_second_i,
   output logic             rel_ready_o,
   input  logic             rb_start_i,
   input  logic             rb_valid_first_i,
   input  logic             rb_valid_second_i,
   input  logic [TAG_W-1:0] rb_tag_first_i,
   input  logic [TAG_W-1:0] rb_tag_second_i,
   input  logic             rb_done_i,
   output logic             fl_rd_first_en_o,
   output logic             fl_rd_second_en_o,
   input  logic [TAG_W-1:0] fl_rdata_first_i,
   input  logic [TAG_W-1:0] fl_rdata_second_i,
   output logic             fl_wr_first_en_o,
   output logic             fl_wr_second_en_o,
   output logic [TAG_W-1:0] fl_wdata_first_o,
   output logic [TAG_W-1:0] fl_wdata_second_o,
   input  logic [CNT_W-1:0] fl_num_i,
   output logic             busy_o
`ifdef FREELIST_CTRL_ERR_EN
   ,
   output logic             err_o
`endif
);

   localparam int unsigned BC_W = $clog2(REL_BUF_DEPTH) + 1;

   fl_state_e        state_q;
   logic             rel_ready_q;
   logic             in_rb;
   logic             alloc_ok;
   logic             push_first;
   logic             push_second;
   logic             pop_first;
   logic             pop_second;
   logic [TAG_W-1:0] head_first;
   logic [TAG_W-1:0] head_second;
   logic [BC_W-1:0]  buf_cnt;
   logic [BC_W-1:0]  buf_cnt_next;

   assign in_rb       = (state_q == StRollback);
   assign busy_o      = (state_q != StRun) & ~rst;
   assign rel_ready_o = rel_ready_q | rst;

   // Allocation is zero-latency; fl_num_i deliberately ignores same-cycle writes.
   always_comb begin
      alloc_ok           = ~rst & (state_q == StRun) & ~rb_start_i;
      alloc_gnt_first_o  = alloc_ok & alloc_req_first_i & (fl_num_i != '0);
      alloc_gnt_second_o = alloc_gnt_first_o & alloc_req_second_i & (fl_num_i >= CNT_W'(2));
      fl_rd_first_en_o   = alloc_gnt_first_o;
      fl_rd_second_en_o  = alloc_gnt_second_o;
      alloc_tag_first_o  = alloc_gnt_first_o ? fl_rdata_first_i : '0;
      alloc_tag_second_o = alloc_gnt_second_o ? fl_rdata_second_i : '0;
   end

   always_comb begin
      push_first  = rel_first_en_i & rel_ready_q & ~rst;
      push_second = rel_second_en_i & rel_ready_q & ~rst;
      pop_first   = ~rst & ~in_rb & (buf_cnt != '0);
      pop_second  = ~rst & ~in_rb & (buf_cnt >= BC_W'(2));
      if (in_rb) begin
         // Single rollback write always rides port 0.
         fl_wr_first_en_o  = ~rst & (rb_valid_first_i | rb_valid_second_i);
         fl_wr_second_en_o = ~rst & rb_valid_first_i & rb_valid_second_i;
         fl_wdata_first_o  = rb_valid_first_i ? rb_tag_first_i : rb_tag_second_i;
         fl_wdata_second_o = rb_tag_second_i;
      end else begin
         fl_wr_first_en_o  = pop_first;
         fl_wr_second_en_o = pop_second;
         fl_wdata_first_o  = head_first;
         fl_wdata_second_o = head_second;
      end
   end

   freelist_rel_buf #(
      .DEPTH (REL_BUF_DEPTH),
      .TAG_W (TAG_W)
   ) u_rel_buf (
      .clk               (clk),
      .rst               (rst),
      .push_first_i      (push_first),
      .push_second_i     (push_second),
      .push_tag_first_i  (rel_tag_first_i),
      .push_tag_second_i (rel_tag_second_i),
      .pop_first_i       (pop_first),
      .pop_second_i      (pop_second),
      .head_first_o      (head_first),
      .head_second_o     (head_second),
      .cnt_o             (buf_cnt),
      .cnt_next_o        (buf_cnt_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StRun;
         rel_ready_q <= 1'b1;
      end else begin
         rel_ready_q <= (buf_cnt_next <= BC_W'(REL_BUF_DEPTH - 2));
         unique case (state_q)
            StRun: begin
               if (rb_start_i) state_q <= StRollback;
            end
            StRollback: begin
               if (rb_done_i) state_q <= (buf_cnt_next != '0) ? StDrain : StRun;
            end
            StDrain: begin
               if (buf_cnt_next == '0) state_q <= StRun;
            end
            default: state_q <= StRun;
         endcase
      end
   end

`ifdef FREELIST_CTRL_ERR_EN
   localparam int unsigned EW = CNT_W + 2;

   logic err_q;
   logic err_set;

   always_comb begin
      err_set = ((rel_first_en_i | rel_second_en_i) & ~rel_ready_q)
              | ((EW'(fl_num_i) + EW'(fl_wr_first_en_o) + EW'(fl_wr_second_en_o))
                 > EW'(PREG_NUM))
              | (alloc_req_second_i & ~alloc_req_first_i)
              | ((rb_valid_first_i | rb_valid_second_i) & ~in_rb);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (err_set) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`endif

endmodule

// File: tb/tb_freelist_ctrl.sv
// Directed self-checking bench for freelist_ctrl (checks err_o when FREELIST_CTRL_ERR_EN is set).
module tb_freelist_ctrl;

   logic       clk;
   logic       rst;
   logic       alloc_req_first_i, alloc_req_second_i;
   logic       alloc_gnt_first_o, alloc_gnt_second_o;
   logic [4:0] alloc_tag_first_o, alloc_tag_second_o;
   logic       rel_first_en_i, rel_second_en_i;
   logic [4:0] rel_tag_first_i, rel_tag_second_i;
   logic       rel_ready_o;
   logic       rb_start_i, rb_valid_first_i, rb_valid_second_i, rb_done_i;
   logic [4:0] rb_tag_first_i, rb_tag_second_i;
   logic       fl_rd_first_en_o, fl_rd_second_en_o;
   logic [4:0] fl_rdata_first_i, fl_rdata_second_i;
   logic       fl_wr_first_en_o, fl_wr_second_en_o;
   logic [4:0] fl_wdata_first_o, fl_wdata_second_o;
   logic [4:0] fl_num_i;
   logic       busy_o;
`ifdef FREELIST_CTRL_ERR_EN
   logic       err_o;
`endif

   int n_checks;
   int n_fail;

   freelist_ctrl dut (
      .clk                (clk),
      .rst                (rst),
      .alloc_req_first_i  (alloc_req_first_i),
      .alloc_req_second_i (alloc_req_second_i),
      .alloc_gnt_first_o  (alloc_gnt_first_o),
      .alloc_gnt_second_o (alloc_gnt_second_o),
      .alloc_tag_first_o  (alloc_tag_first_o),
      .alloc_tag_second_o (alloc_tag_second_o),
      .rel_first_en_i     (rel_first_en_i),
      .rel_second_en_i    (rel_second_en_i),
      .rel_tag_first_i    (rel_tag_first_i),
      .rel_tag_second_i   (rel_tag_second_i),
      .rel_ready_o        (rel_ready_o),
      .rb_start_i         (rb_start_i),
      .rb_valid_first_i   (rb_valid_first_i),
      .rb_valid_second_i  (rb_valid_second_i),
      .rb_tag_first_i     (rb_tag_first_i),
      .rb_tag_second_i    (rb_tag_second_i),
      .rb_done_i          (rb_done_i),
      .fl_rd_first_en_o   (fl_rd_first_en_o),
      .fl_rd_second_en_o  (fl_rd_second_en_o),
      .fl_rdata_first_i   (fl_rdata_first_i),
      .fl_rdata_second_i  (fl_rdata_second_i),
      .fl_wr_first_en_o   (fl_wr_first_en_o),
      .fl_wr_second_en_o  (fl_wr_second_en_o),
      .fl_wdata_first_o   (fl_wdata_first_o),
      .fl_wdata_second_o  (fl_wdata_second_o),
      .fl_num_i           (fl_num_i),
      .busy_o             (busy_o)
`ifdef FREELIST_CTRL_ERR_EN
      ,
      .err_o              (err_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {gnt0, gnt1, rd0, rd1, tag0, tag1}
   function automatic logic [13:0] obs_alloc();
      return {alloc_gnt_first_o, alloc_gnt_second_o, fl_rd_first_en_o, fl_rd_second_en_o,
              alloc_tag_first_o, alloc_tag_second_o};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alloc_req_first_i  = 1'b0;
      alloc_req_second_i = 1'b0;
      rel_first_en_i     = 1'b0;
      rel_second_en_i    = 1'b0;
      rel_tag_first_i    = '0;
      rel_tag_second_i   = '0;
      rb_start_i         = 1'b0;
      rb_valid_first_i   = 1'b0;
      rb_valid_second_i  = 1'b0;
      rb_tag_first_i     = '0;
      rb_tag_second_i    = '0;
      rb_done_i          = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      alloc_req_first_i  = 1'b1;
      alloc_req_second_i = 1'b1;
      fl_num_i           = 5'd5;
      fl_rdata_first_i   = 5'd1;
      fl_rdata_second_i  = 5'd2;
      step();
      @(negedge clk);
      n_checks++;
      if (obs_alloc() !== 14'd0) begin
         n_fail++;
         $display("FAIL rst_alloc: got %h want %h", obs_alloc(), 14'd0);
      end
      n_checks++;
      if ({busy_o, rel_ready_o, fl_wr_first_en_o, fl_wr_second_en_o} !== 4'b0100) begin
         n_fail++;
         $display("FAIL rst_ctl: got %b want 0100",
                  {busy_o, rel_ready_o, fl_wr_first_en_o, fl_wr_second_en_o});
      end
      step();
      rst = 1'b0;
      idle_inputs();
      fl_num_i = 5'd0;
      @(negedge clk);
      n_checks++;
      if ({busy_o, rel_ready_o, fl_wr_first_en_o, fl_wr_second_en_o} !== 4'b0100) begin
         n_fail++;
         $display("FAIL post_rst_ctl: got %b want 0100",
                  {busy_o, rel_ready_o, fl_wr_first_en_o, fl_wr_second_en_o});
      end
      step();
   endtask

   task automatic test_alloc();
      logic [13:0] exp [4];
      logic [4:0]  num [4];
      logic [1:0]  req [4];
      exp[0] = {4'b1111, 5'd7, 5'd9}; num[0] = 5'd2; req[0] = 2'b11;
      exp[1] = {4'b1010, 5'd7, 5'd0}; num[1] = 5'd1; req[1] = 2'b11;
      exp[2] = {4'b0000, 5'd0, 5'd0}; num[2] = 5'd0; req[2] = 2'b11;
      exp[3] = {4'b0000, 5'd0, 5'd0}; num[3] = 5'd5; req[3] = 2'b01;
      fl_rdata_first_i  = 5'd7;
      fl_rdata_second_i = 5'd9;
      for (int i = 0; i < 4; i++) begin
         alloc_req_first_i  = req[i][1];
         alloc_req_second_i = req[i][0];
         fl_num_i           = num[i];
         @(negedge clk);
         n_checks++;
         if (obs_alloc() !== exp[i]) begin
            n_fail++;
            $display("FAIL alloc_vec%0d: got %h want %h", i, obs_alloc(), exp[i]);
         end
         step();
      end
      idle_inputs();
      fl_num_i = 5'd0;
   endtask

   task automatic test_release();
      rel_first_en_i   = 1'b1;
      rel_second_en_i  = 1'b1;
      rel_tag_first_i  = 5'd3;
      rel_tag_second_i = 5'd4;
      @(negedge clk);
      n_checks++;
      if ({fl_wr_first_en_o, fl_wr_second_en_o} !== 2'b00) begin
         n_fail++;
         $display("FAIL rel_same_cycle: got %b want 00", {fl_wr_first_en_o, fl_wr_second_en_o});
      end
      step();
      rel_first_en_i   = 1'b0;
      rel_second_en_i  = 1'b1;
      rel_tag_second_i = 5'd6;
      @(negedge clk);
      n_checks++;
      if ({fl_wr_first_en_o, fl_wr_second_en_o, fl_wdata_first_o, fl_wdata_second_o}
          !== {2'b11, 5'd3, 5'd4}) begin
         n_fail++;
         $display("FAIL rel_pair_write: got %h want %h",
                  {fl_wr_first_en_o, fl_wr_second_en_o, fl_wdata_first_o, fl_wdata_second_o},
                  {2'b11, 5'd3, 5'd4});
      end
      step();
      idle_inputs();
      @(negedge clk);
      n_checks++;
      if ({fl_wr_first_en_o, fl_wr_second_en_o, fl_wdata_first_o} !== {2'b10, 5'd6}) begin
         n_fail++;
         $display("FAIL rel_slot1_only: got %h want %h",
                  {fl_wr_first_en_o, fl_wr_second_en_o, fl_wdata_first_o}, {2'b10, 5'd6});
      end
      step();
      @(negedge clk);
      n_checks++;
      if ({fl_wr_first_en_o, fl_wr_second_en_o, rel_ready_o} !== 3'b001) begin
         n_fail++;
         $display("FAIL rel_empty: got %b want 001",
                  {fl_wr_first_en_o, fl_wr_second_en_o, rel_ready_o});
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [4:0] t0 [4];
      logic [4:0] t1 [4];
      logic       rdy [4];
      t0[0] = 5'd1;  t1[0] = 5'd2;  rdy[0] = 1'b1;
      t0[1] = 5'd3;  t1[1] = 5'd4;  rdy[1] = 1'b1;
      t0[2] = 5'd20; t1[2] = 5'd21; rdy[2] = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      rb_start_i = 1'b1;
      step();
      rb_start_i = 1'b0;
      // Three release pairs while pops are blocked; the third is dropped.
      for (int i = 0; i < 3; i++) begin
         rel_first_en_i   = 1'b1;
         rel_second_en_i  = 1'b1;
         rel_tag_first_i  = t0[i];
         rel_tag_second_i = t1[i];
         @(negedge clk);
         n_checks++;
         if ({busy_o, rel_ready_o, fl_wr_first_en_o, fl_wr_second_en_o} !== {1'b1, rdy[i], 2'b00})
         begin
            n_fail++;
            $display("FAIL b2b_push%0d: got %b want %b", i,
                     {busy_o, rel_ready_o, fl_wr_first_en_o, fl_wr_second_en_o},
                     {1'b1, rdy[i], 2'b00});
         end
`ifdef FREELIST_CTRL_ERR_EN
         if (i == 1) begin
            n_checks++;
            if (err_o !== 1'b0) begin
               n_fail++;
               $display("FAIL err_clean: got %b want 0", err_o);
            end
         end
`endif
         step();
      end
      idle_inputs();
      rb_done_i = 1'b1;
      step();
      idle_inputs();
      alloc_req_first_i  = 1'b1;
      alloc_req_second_i = 1'b1;
      fl_num_i           = 5'd5;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++;
         if ({busy_o, fl_wr_first_en_o, fl_wr_second_en_o, fl_wdata_first_o, fl_wdata_second_o,
              alloc_gnt_first_o} !== {3'b111, t0[i], t1[i], 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_drain%0d: got %h want %h", i,
                     {busy_o, fl_wr_first_en_o, fl_wr_second_en_o, fl_wdata_first_o,
                      fl_wdata_second_o, alloc_gnt_first_o},
                     {3'b111, t0[i], t1[i], 1'b0});
         end
         step();
      end
      alloc_req_first_i  = 1'b0;
      alloc_req_second_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({busy_o, rel_ready_o, fl_wr_first_en_o, fl_wr_second_en_o} !== 4'b0100) begin
         n_fail++;
         $display("FAIL b2b_done: got %b want 0100",
                  {busy_o, rel_ready_o, fl_wr_first_en_o, fl_wr_second_en_o});
      end
`ifdef FREELIST_CTRL_ERR_EN
      n_checks++;
      if (err_o !== 1'b1) begin
         n_fail++;
         $display("FAIL err_overflow_push: got %b want 1", err_o);
      end
`endif
      step();
   endtask

   task automatic test_rollback();
      alloc_req_first_i  = 1'b1;
      alloc_req_second_i = 1'b1;
      fl_num_i           = 5'd5;
      fl_rdata_first_i   = 5'd7;
      fl_rdata_second_i  = 5'd9;
      rb_start_i         = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy_o, alloc_gnt_first_o, alloc_gnt_second_o, fl_rd_first_en_o} !== 4'b0000) begin
         n_fail++;
         $display("FAIL rb_start_gnt: got %b want 0000",
                  {busy_o, alloc_gnt_first_o, alloc_gnt_second_o, fl_rd_first_en_o});
      end
      step();
      rb_start_i        = 1'b0;
      rb_valid_first_i  = 1'b1;
      rb_valid_second_i = 1'b1;
      rb_tag_first_i    = 5'd10;
      rb_tag_second_i   = 5'd11;
      rel_first_en_i    = 1'b1;
      rel_tag_first_i   = 5'd5;
      @(negedge clk);
      n_checks++;
      if ({busy_o, alloc_gnt_first_o, fl_wr_first_en_o, fl_wr_second_en_o, fl_wdata_first_o,
           fl_wdata_second_o} !== {4'b1011, 5'd10, 5'd11}) begin
         n_fail++;
         $display("FAIL rb_beat0: got %h want %h",
                  {busy_o, alloc_gnt_first_o, fl_wr_first_en_o, fl_wr_second_en_o,
                   fl_wdata_first_o, fl_wdata_second_o}, {4'b1011, 5'd10, 5'd11});
      end
      step();
      rel_first_en_i   = 1'b0;
      rb_valid_first_i = 1'b0;
      rb_tag_first_i   = 5'd0;
      rb_tag_second_i  = 5'd12;
      rb_done_i        = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy_o, alloc_gnt_first_o, fl_wr_first_en_o, fl_wr_second_en_o, fl_wdata_first_o}
          !== {4'b1010, 5'd12}) begin
         n_fail++;
         $display("FAIL rb_beat1_remap: got %h want %h",
                  {busy_o, alloc_gnt_first_o, fl_wr_first_en_o, fl_wr_second_en_o,
                   fl_wdata_first_o}, {4'b1010, 5'd12});
      end
      step();
      rb_valid_second_i = 1'b0;
      rb_done_i         = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({busy_o, alloc_gnt_first_o, fl_wr_first_en_o, fl_wr_second_en_o, fl_wdata_first_o}
          !== {4'b1010, 5'd5}) begin
         n_fail++;
         $display("FAIL rb_drain: got %h want %h",
                  {busy_o, alloc_gnt_first_o, fl_wr_first_en_o, fl_wr_second_en_o,
                   fl_wdata_first_o}, {4'b1010, 5'd5});
      end
      step();
      @(negedge clk);
      n_checks++;
      if ({busy_o, fl_wr_first_en_o, fl_wr_second_en_o} !== 3'b000
          || obs_alloc() !== {4'b1111, 5'd7, 5'd9}) begin
         n_fail++;
         $display("FAIL rb_back_to_run: got %b/%h want 000/%h",
                  {busy_o, fl_wr_first_en_o, fl_wr_second_en_o}, obs_alloc(),
                  {4'b1111, 5'd7, 5'd9});
      end
`ifdef FREELIST_CTRL_ERR_EN
      n_checks++;
      if (err_o !== 1'b1) begin
         n_fail++;
         $display("FAIL err_sticky: got %b want 1", err_o);
      end
`endif
      step();
      idle_inputs();
   endtask

   task automatic test_reset_midrb();
      fl_num_i   = 5'd5;
      rb_start_i = 1'b1;
      step();
      rb_start_i       = 1'b0;
      rel_first_en_i   = 1'b1;
      rel_second_en_i  = 1'b1;
      rel_tag_first_i  = 5'd8;
      rel_tag_second_i = 5'd9;
      step();
      idle_inputs();
      rst                = 1'b1;
      rb_valid_first_i   = 1'b1;
      rb_tag_first_i     = 5'd30;
      alloc_req_first_i  = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy_o, rel_ready_o, fl_wr_first_en_o, fl_wr_second_en_o, alloc_gnt_first_o}
          !== 5'b01000) begin
         n_fail++;
         $display("FAIL midrb_in_rst: got %b want 01000",
                  {busy_o, rel_ready_o, fl_wr_first_en_o, fl_wr_second_en_o, alloc_gnt_first_o});
      end
      step();
      rst = 1'b0;
      idle_inputs();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++;
         if ({busy_o, rel_ready_o, fl_wr_first_en_o, fl_wr_second_en_o} !== 4'b0100) begin
            n_fail++;
            $display("FAIL midrb_after%0d: got %b want 0100", i,
                     {busy_o, rel_ready_o, fl_wr_first_en_o, fl_wr_second_en_o});
         end
`ifdef FREELIST_CTRL_ERR_EN
         n_checks++;
         if (err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL err_cleared%0d: got %b want 0", i, err_o);
         end
`endif
         step();
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      fl_num_i = '0;
      fl_rdata_first_i  = '0;
      fl_rdata_second_i = '0;
      idle_inputs();
      test_reset();
      test_alloc();
      test_release();
      test_back_to_back();
      test_rollback();
      test_reset_midrb();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
